data_deshuffler_3p: RTL

Reorders 3-lane parallel FFT sample streams back into natural lane/period order. It sits at the output side of a 3-parallel FFT stage and undoes the lane/period interleave the data shuffler applies on the input side. Each frame of 3 periods × DEPTH beats is treated as a 3×3 block transpose: input lane i in period p becomes output lane p in period i. Two frame banks are used ping-pong style, so input accepts one beat every cycle with no backpressure.

---
 rtl/fft_shuffle_pkg.sv | 21 ++
 rtl/frame_bank.sv | 40 ++++
 rtl/data_deshuffler_3p.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/fft_shuffle_pkg.sv
// Shared constants, sizing helper and reader state type for the 3-parallel
// FFT shuffle/deshuffle blocks.
package fft_shuffle_pkg;

  localparam int unsigned LANES   = 3;
  localparam int unsigned PERIODS = 3;

  // Bits needed to index n entries; never returns less than 1.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r = r + 1;
    return (r == 0) ? 32'd1 : r;
  endfunction

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } rd_state_e;

endpackage

// File: rtl/frame_bank.sv
// One frame of storage: PERIODS x LANES x DEPTH samples of W bits.
// Ports:
//   clk                 - clock
//   we                  - write strobe for one input beat
//   wr_period, wr_idx   - period and beat index of the write
//   wr_data             - the 3-lane input vector
//   rd_period, rd_idx   - transposed read address
//   rd_data_c           - combinational 3-lane read vector; lane j returns
//                         the sample written in period j, lane rd_period
module frame_bank
  import fft_shuffle_pkg::*;
#(
  parameter int unsigned W     = 32,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PW   = clog2(PERIODS),
  localparam int unsigned KW   = clog2(DEPTH)
) (
  input  logic                        clk,
  input  logic                        we,
  input  logic [PW-1:0]               wr_period,
  input  logic [KW-1:0]               wr_idx,
  input  logic [LANES-1:0][W-1:0]     wr_data,
  input  logic [PW-1:0]               rd_period,
  input  logic [KW-1:0]               rd_idx,
  output logic [LANES-1:0][W-1:0]     rd_data_c
);

  logic [W-1:0] mem [PERIODS][LANES][DEPTH];

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    // Write port: lane i of the beat lands in its own lane slot.
    always_ff @(posedge clk) begin
      if (we) mem[wr_period][i][wr_idx] <= wr_data[i];
    end

    // Read port: the period and lane axes swap places.
    assign rd_data_c[i] = mem[i][rd_period][rd_idx];
  end

endmodule

// File: rtl/data_deshuffler_3p.sv
// Undoes the 3-lane lane/period interleave at the output of a 3-parallel FFT
// stage. Each 3*DEPTH-beat frame is written into one of two ping-pong banks
// and read back as a 3x3 block transpose, so input never stalls.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   in_valid            - input beat present (gaps allowed)
//   in0..in2            - input lanes
//   out_valid, out_sop  - output beat valid, first beat of a frame
//   out0..out2          - output lanes (zero when out_valid is low)
module data_deshuffler_3p
  import fft_shuffle_pkg::*;
#(
  parameter int unsigned W     = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in0,
  input  logic [W-1:0] in1,
  input  logic [W-1:0] in2,
  output logic         out_valid,
  output logic         out_sop,
  output logic [W-1:0] out0,
  output logic [W-1:0] out1,
  output logic [W-1:0] out2
);

  localparam int unsigned PW = clog2(PERIODS);
  localparam int unsigned KW = clog2(DEPTH);
  localparam logic [PW-1:0] LAST_P = PW'(PERIODS - 1);
  localparam logic [KW-1:0] LAST_K = KW'(DEPTH - 1);

  // Writer state
  logic          wb;
  logic [PW-1:0] wp;
  logic [KW-1:0] wk;
  logic          frame_done_c;
  logic [1:0]    we_c;
  logic [1:0]    full_set_c;
  logic [LANES-1:0][W-1:0] wr_data_c;

  // Reader state
  rd_state_e     state, state_d;
  logic          rb, rb_d;
  logic [PW-1:0] rq, rq_d;
  logic [KW-1:0] rk, rk_d;
  logic [1:0]    full;
  logic [1:0]    full_clr_c;
  logic          emit_c, sop_c, rd_bank_c;
  logic [PW-1:0] rd_q_c;
  logic [KW-1:0] rd_k_c;
  logic [LANES-1:0][W-1:0] rd_data_c [2];
  logic [LANES-1:0][W-1:0] rd_vec_c;

  assign wr_data_c    = {in2, in1, in0};
  assign frame_done_c = in_valid && (wp == LAST_P) && (wk == LAST_K);
  // A beat arriving in the reset cycle is dropped.
  assign we_c[0]      = in_valid && !rst && !wb;
  assign we_c[1]      = in_valid && !rst && wb;
  assign full_set_c   = frame_done_c ? (wb ? 2'b10 : 2'b01) : 2'b00;

  frame_bank #(.W(W), .DEPTH(DEPTH)) u_bank0 (
    .clk       (clk),
    .we        (we_c[0]),
    .wr_period (wp),
    .wr_idx    (wk),
    .wr_data   (wr_data_c),
    .rd_period (rd_q_c),
    .rd_idx    (rd_k_c),
    .rd_data_c (rd_data_c[0])
  );

  frame_bank #(.W(W), .DEPTH(DEPTH)) u_bank1 (
    .clk       (clk),
    .we        (we_c[1]),
    .wr_period (wp),
    .wr_idx    (wk),
    .wr_data   (wr_data_c),
    .rd_period (rd_q_c),
    .rd_idx    (rd_k_c),
    .rd_data_c (rd_data_c[1])
  );

  assign rd_vec_c = rd_bank_c ? rd_data_c[1] : rd_data_c[0];

  // Write counters: index, then period, then bank toggle at frame end.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb <= 1'b0;
      wp <= '0;
      wk <= '0;
    end else if (in_valid) begin
      if (wk == LAST_K) begin
        wk <= '0;
        if (wp == LAST_P) begin
          wp <= '0;
          wb <= ~wb;
        end else begin
          wp <= PW'(wp + 1'b1);
        end
      end else begin
        wk <= KW'(wk + 1'b1);
      end
    end
  end

  // Reader next state. rq/rk address the beat currently on the outputs;
  // rd_* address the beat to be registered at the next edge.
  always_comb begin
    state_d    = state;
    rb_d       = rb;
    rq_d       = rq;
    rk_d       = rk;
    emit_c     = 1'b0;
    sop_c      = 1'b0;
    rd_bank_c  = rb;
    rd_q_c     = rq;
    rd_k_c     = rk;
    full_clr_c = 2'b00;

    case (state)
      IDLE: begin
        if (full != 2'b00) begin
          emit_c    = 1'b1;
          sop_c     = 1'b1;
          rd_bank_c = full[0] ? 1'b0 : 1'b1;
          rd_q_c    = '0;
          rd_k_c    = '0;
          rb_d      = rd_bank_c;
          rq_d      = '0;
          rk_d      = '0;
          state_d   = DRAIN;
        end
      end
      DRAIN: begin
        if ((rq == LAST_P) && (rk == LAST_K)) begin
          // Last beat is showing: release the bank, chain into the other
          // bank without a bubble if it has already filled.
          full_clr_c[rb] = 1'b1;
          if (full[~rb]) begin
            emit_c    = 1'b1;
            sop_c     = 1'b1;
            rd_bank_c = ~rb;
            rd_q_c    = '0;
            rd_k_c    = '0;
            rb_d      = ~rb;
            rq_d      = '0;
            rk_d      = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          emit_c = 1'b1;
          if (rk == LAST_K) begin
            rk_d = '0;
            rq_d = PW'(rq + 1'b1);
          end else begin
            rk_d = KW'(rk + 1'b1);
          end
          rd_q_c = rq_d;
          rd_k_c = rk_d;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Reader registers, bank-full flags and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rb        <= 1'b0;
      rq        <= '0;
      rk        <= '0;
      full      <= 2'b00;
      out_valid <= 1'b0;
      out_sop   <= 1'b0;
      out0      <= '0;
      out1      <= '0;
      out2      <= '0;
    end else begin
      state     <= state_d;
      rb        <= rb_d;
      rq        <= rq_d;
      rk        <= rk_d;
      full      <= (full & ~full_clr_c) | full_set_c;
      out_valid <= emit_c;
      out_sop   <= sop_c;
      out0      <= emit_c ? rd_vec_c[0] : '0;
      out1      <= emit_c ? rd_vec_c[1] : '0;
      out2      <= emit_c ? rd_vec_c[2] : '0;
    end
  end

endmodule
